// File: rtl/tlc_pkg.sv
// Shared types and default timing for the timed traffic light controller.
//   tlc_state_t : 3-bit controller state; the encoding is visible on the
//                 debug phase output, so the values are fixed.
//   DEF_*       : default phase durations in clock cycles.
package tlc_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    EW_GREEN  = 3'd2,
    EW_YELLOW = 3'd3,
    ALL_RED   = 3'd4,
    PED_WALK  = 3'd5,
    PED_FLASH = 3'd6
  } tlc_state_t;

  localparam int DEF_CNT_W     = 8;
  localparam int DEF_MIN_GREEN = 6;
  localparam int DEF_MAX_GREEN = 16;
  localparam int DEF_YELLOW    = 1;
  localparam int DEF_ALL_RED   = 1;
  localparam int DEF_WALK      = 2;
  localparam int DEF_FLASH     = 2;

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase timer: CNT_W-bit counter that clears synchronously and otherwise
// counts up, holding at all ones. done flags the last cycle of a phase of
// length dur, i.e. cnt == dur-1.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the phase (cnt becomes 0 on the next edge)
//   dur      : duration of the current phase in cycles (>= 1)
//   cnt      : cycles spent in the current phase so far
//   done     : current cycle is the last one of the phase
module tlc_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] dur,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == dur - 1'b1);

endmodule

// File: rtl/tlc_timed_fsm.sv
// Two-approach traffic light controller with a latched pedestrian phase.
// NS is the rest road; EW green is capped at MAX_GREEN while EW is held.
// Every yellow is followed by an all-red clearance; a pending pedestrian
// request is served from that clearance.
//   clk, rst             : clock, synchronous active-high reset
//   ns_req, ew_req       : vehicle demand levels
//   ped_req              : pedestrian button (pulse or level)
//   g_/y_/r_ns, g_/y_/r_ew : lamp drives, exactly one lit per road
//   walk, dn_walk        : pedestrian signal drives
//   phase                : current state encoding (debug)
module tlc_timed_fsm
  import tlc_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int MAX_GREEN = DEF_MAX_GREEN,
  parameter int YELLOW    = DEF_YELLOW,
  parameter int ALL_RED_T = DEF_ALL_RED,
  parameter int WALK      = DEF_WALK,
  parameter int FLASH     = DEF_FLASH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic       g_ns,
  output logic       y_ns,
  output logic       r_ns,
  output logic       g_ew,
  output logic       y_ew,
  output logic       r_ew,
  output logic       walk,
  output logic       dn_walk,
  output logic [2:0] phase
);

  localparam int MAX_DUR = 2**CNT_W - 1;

  if (MIN_GREEN < 1 || MIN_GREEN > MAX_DUR || MAX_GREEN < 1 || MAX_GREEN > MAX_DUR ||
      YELLOW < 1 || YELLOW > MAX_DUR || ALL_RED_T < 1 || ALL_RED_T > MAX_DUR ||
      WALK < 1 || WALK > MAX_DUR || FLASH < 1 || FLASH > MAX_DUR) begin : g_bad_duration
    $error("tlc_timed_fsm: every duration must be in 1 .. 2**CNT_W-1");
  end
  if (MAX_GREEN < MIN_GREEN) begin : g_bad_max_green
    $error("tlc_timed_fsm: MAX_GREEN must be at least MIN_GREEN");
  end

  tlc_state_t       state_q, state_d;
  logic             pend_q, from_ns_q;
  logic [CNT_W-1:0] cnt, dur;
  logic             done, clr, ped, min_ok, cap, in_ped;

  tlc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .dur  (dur),
    .cnt  (cnt),
    .done (done)
  );

  assign ped    = ped_req | pend_q;
  assign min_ok = (cnt >= CNT_W'(MIN_GREEN - 1));
  assign cap    = (cnt == CNT_W'(MAX_GREEN - 1));
  assign in_ped = (state_q == PED_WALK) || (state_q == PED_FLASH);
  // Any state change restarts the phase timer.
  assign clr    = (state_d != state_q);

  // Greens use min_ok/cap rather than done, so their dur is don't-care.
  always_comb begin
    // NOTE: a default on every combinational output before the case keeps
    // unlisted paths from inferring latches.
    dur = CNT_W'(MIN_GREEN);
    case (state_q)
      NS_YELLOW, EW_YELLOW: dur = CNT_W'(YELLOW);
      ALL_RED:              dur = CNT_W'(ALL_RED_T);
      PED_WALK:             dur = CNT_W'(WALK);
      PED_FLASH:            dur = CNT_W'(FLASH);
      default:              dur = CNT_W'(MIN_GREEN);
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_GREEN:  if (min_ok && (ew_req || ped)) state_d = NS_YELLOW;
      // EW keeps green only while it alone has demand, and never past the cap.
      EW_GREEN:  if (min_ok && (!(ew_req && !ns_req && !ped) || cap)) state_d = EW_YELLOW;
      NS_YELLOW, EW_YELLOW: if (done) state_d = ALL_RED;
      ALL_RED: begin
        if (done) begin
          if (pend_q)         state_d = PED_WALK;
          else if (from_ns_q) state_d = EW_GREEN;
          else                state_d = NS_GREEN;
        end
      end
      PED_WALK:  if (done) state_d = PED_FLASH;
      PED_FLASH: if (done) state_d = (from_ns_q && ew_req) ? EW_GREEN : NS_GREEN;
      default:   state_d = NS_GREEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= NS_GREEN;
      pend_q    <= 1'b0;
      from_ns_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Entry to the walk phase consumes the request, even if pressed again.
      if (state_d == PED_WALK && state_q != PED_WALK) pend_q <= 1'b0;
      else if (ped_req && !in_ped)                  pend_q <= 1'b1;
      if (state_q == NS_YELLOW && state_d == ALL_RED)      from_ns_q <= 1'b1;
      else if (state_q == EW_YELLOW && state_d == ALL_RED) from_ns_q <= 1'b0;
    end
  end

  // Moore decode from the state register; unused encodings show NS_GREEN.
  always_comb begin
    g_ns = 1'b0; y_ns = 1'b0; r_ns = 1'b1;
    g_ew = 1'b0; y_ew = 1'b0; r_ew = 1'b1;
    walk = 1'b0; dn_walk = 1'b1;
    case (state_q)
      NS_YELLOW: begin y_ns = 1'b1; r_ns = 1'b0; end
      EW_GREEN:  begin g_ew = 1'b1; r_ew = 1'b0; end
      EW_YELLOW: begin y_ew = 1'b1; r_ew = 1'b0; end
      ALL_RED:   ;
      PED_WALK:  begin walk = 1'b1; dn_walk = 1'b0; end
      // Flashing starts dark because cnt is 0 on entry.
      PED_FLASH: dn_walk = cnt[0];
      default:   begin g_ns = 1'b1; r_ns = 1'b0; end
    endcase
  end

  assign phase = (state_q == PED_FLASH || state_q == PED_WALK || state_q == ALL_RED ||
                  state_q == EW_YELLOW || state_q == EW_GREEN || state_q == NS_YELLOW)
                 ? state_q : NS_GREEN;

endmodule

// File: tb/tb_tlc_timed_fsm.sv
// Directed bench for tlc_timed_fsm at default parameters. Each cycle's
// expected phase/lamp vector is queued when the inputs are driven and
// popped for comparison on the following falling edge.
module tb_tlc_timed_fsm;

  logic clk = 1'b0;
  logic rst, ns_req, ew_req, ped_req;
  logic g_ns, y_ns, r_ns, g_ew, y_ew, r_ew, walk, dn_walk;
  logic [2:0] phase;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [10:0] v;
  } exp_t;

  exp_t sb[$];

  tlc_timed_fsm dut (
    .clk     (clk),
    .rst     (rst),
    .ns_req  (ns_req),
    .ew_req  (ew_req),
    .ped_req (ped_req),
    .g_ns    (g_ns),
    .y_ns    (y_ns),
    .r_ns    (r_ns),
    .g_ew    (g_ew),
    .y_ew    (y_ew),
    .r_ew    (r_ew),
    .walk    (walk),
    .dn_walk (dn_walk),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // {phase, g_ns, y_ns, r_ns, g_ew, y_ew, r_ew, walk, dn_walk}
  function automatic logic [10:0] exp_vec(input int ph, input logic dnf);
    case (ph)
      0:       return {3'd0, 8'b100_001_01};
      1:       return {3'd1, 8'b010_001_01};
      2:       return {3'd2, 8'b001_100_01};
      3:       return {3'd3, 8'b001_010_01};
      4:       return {3'd4, 8'b001_001_01};
      5:       return {3'd5, 8'b001_001_10};
      default: return {3'd6, 7'b001_001_0, dnf};
    endcase
  endfunction

  function automatic logic [10:0] obs_vec();
    return {phase, g_ns, y_ns, r_ns, g_ew, y_ew, r_ew, walk, dn_walk};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Called just after a rising edge with this cycle's inputs already driven.
  task automatic step(input string tag, input int ph, input logic dnf);
    exp_t e;
    e.tag = tag;
    e.v   = exp_vec(ph, dnf);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk(e.tag, 16'(obs_vec()), 16'(e.v));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ns_req = 1'b0; ew_req = 1'b0; ped_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", 16'(obs_vec()), 16'(exp_vec(0, 1'b1)));
    chk("reset_pend", 16'(dut.pend_q), 16'd0);
    rst = 1'b0;
  endtask

  function automatic int ped_seq(input int c);
    if (c <= 5) return 0;
    if (c == 6) return 1;
    if (c == 7) return 4;
    if (c <= 9) return 5;
    if (c <= 11) return 6;
    return 0;
  endfunction

  initial begin
    // Idle: NS rests indefinitely.
    do_reset();
    for (int c = 0; c < 50; c++) step($sformatf("idle_c%0d", c), 0, 1'b1);

    // EW held from reset: NS min green, then EW capped at MAX_GREEN.
    do_reset();
    ew_req = 1'b1;
    for (int c = 0; c <= 26; c++) begin
      int ph;
      ph = (c <= 5) ? 0 : (c == 6) ? 1 : (c == 7) ? 4 :
           (c <= 23) ? 2 : (c == 24) ? 3 : (c == 25) ? 4 : 0;
      step($sformatf("ewcap_c%0d", c), ph, 1'b0);
    end

    // Single pedestrian pulse at cycle 2.
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      ped_req = (c == 2);
      if (c == 5) chk("ped_pend_c5", 16'(dut.pend_q), 16'd1);
      if (c == 8) chk("ped_pend_c8", 16'(dut.pend_q), 16'd0);
      step($sformatf("ped_c%0d", c), ped_seq(c), (c == 11));
    end
    ped_req = 1'b0;

    // NS demand during EW green at cnt=7 ends EW early.
    do_reset();
    ew_req = 1'b1;
    for (int c = 0; c <= 18; c++) begin
      int ph;
      ns_req = (c >= 15);
      ph = (c <= 5) ? 0 : (c == 6) ? 1 : (c == 7) ? 4 :
           (c <= 15) ? 2 : (c == 16) ? 3 : (c == 17) ? 4 : 0;
      step($sformatf("nsreq_c%0d", c), ph, 1'b0);
    end
    ns_req = 1'b0; ew_req = 1'b0;

    // ped_req held high: ignored during the pedestrian phase, then forces
    // the next NS green out at its minimum.
    do_reset();
    ped_req = 1'b1;
    for (int c = 0; c <= 18; c++) begin
      int ph;
      ph = (c <= 11) ? ped_seq(c) : (c <= 17) ? 0 : 1;
      if (c == 1)  chk("hold_pend_c1", 16'(dut.pend_q), 16'd1);
      if (c == 8)  chk("hold_pend_c8", 16'(dut.pend_q), 16'd0);
      if (c == 12) chk("hold_pend_c12", 16'(dut.pend_q), 16'd0);
      step($sformatf("hold_c%0d", c), ph, (c == 11));
    end
    ped_req = 1'b0;

    // Reset during PED_FLASH abandons the phase at once.
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      ped_req = (c == 2);
      if (c == 10) begin
        chk("rstflash_from_ns", 16'(dut.from_ns_q), 16'd1);
        rst = 1'b1;
      end
      step($sformatf("rstflash_c%0d", c), ped_seq(c), 1'b0);
    end
    rst = 1'b0;
    chk("rstflash_pend", 16'(dut.pend_q), 16'd0);
    chk("rstflash_from_ns0", 16'(dut.from_ns_q), 16'd0);
    chk("rstflash_cnt", 16'(dut.cnt), 16'd0);
    step("rstflash_after", 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
